// File: rtl/pattern_scheduler.sv
// Pattern buffer playback scheduler: walks a latched buffer sequence through the bank,
// registers the bank byte into a valid/ready stage and arbitrates host buffer reloads.
module pattern_scheduler #(
    parameter  int unsigned NBUFS      = 8,
    parameter  int unsigned FIRSTFIELD = 3,
    parameter  int unsigned LASTFIELD  = 26,
    parameter  int unsigned MAXSEQ     = 5,
    localparam int unsigned BW         = $clog2(NBUFS),
    localparam int unsigned FW         = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [7:0]    seq1,
    input  logic [7:0]    seq2,
    input  logic [7:0]    seqctrl,
    output logic [BW-1:0] bufp,
    output logic [FW-1:0] fieldp,
    input  logic [7:0]    patternbyte,
    output logic [7:0]    pat_data,
    output logic          pat_valid,
    input  logic          pat_ready,
    output logic          busy,
    output logic          done,
    input  logic          wr_req,
    input  logic [BW-1:0] wr_addr,
    output logic          wr_gnt
);

    localparam int unsigned SW = BW * MAXSEQ;
    localparam int unsigned LW = 3;
    localparam logic [LW-1:0] MAXLEN      = LW'(MAXSEQ);
    localparam logic [FW-1:0] FIRST_FIELD = FW'(FIRSTFIELD);
    localparam logic [FW-1:0] LAST_FIELD  = FW'(LASTFIELD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   seq_q;
    logic [LW-1:0]   len_q;
    logic            loop_q;
    logic [LW-1:0]   idx_q;

    logic [SW-1:0]   seq_in_c;
    logic [LW-1:0]   len_in_c;
    logic            at_last_c;
    logic            last_entry_c;
    logic            wraps_c;
    logic [LW-1:0]   next_idx_c;
    logic [BW-1:0]   next_buf_c;
    logic            stall_c;
    logic            xfer_c;
    logic            unused_ok;

    // Buffer number held in sequence slot k.
    function automatic logic [BW-1:0] entry_of(input logic [SW-1:0] s, input logic [LW-1:0] k);
        entry_of = BW'(s >> (BW * k));
    endfunction

    assign unused_ok = ^{seqctrl[7:4], seq2[7]};

    // Pointer-advance lookahead; the stall compares the post-advance buffer with the granted one.
    always_comb begin
        seq_in_c     = SW'({seq2, seq1});
        len_in_c     = (seqctrl[2:0] > MAXLEN) ? MAXLEN : seqctrl[2:0];
        at_last_c    = (fieldp == LAST_FIELD);
        last_entry_c = (idx_q == len_q - LW'(1));
        wraps_c      = at_last_c && !(last_entry_c && !loop_q);
        next_idx_c   = last_entry_c ? '0 : idx_q + LW'(1);
        next_buf_c   = wraps_c ? entry_of(seq_q, next_idx_c) : bufp;
        stall_c      = wr_gnt && (next_buf_c == wr_addr);
        xfer_c       = (!pat_valid || pat_ready) && !stall_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            seq_q     <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            idx_q     <= '0;
            bufp      <= '0;
            fieldp    <= '0;
            pat_data  <= '0;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_gnt    <= 1'b0;
        end else begin
            done   <= 1'b0;
            // A held grant stays; a new one is refused only for the buffer now playing.
            wr_gnt <= wr_req && (wr_gnt || (state == ST_IDLE) || (wr_addr != bufp));
            case (state)
                ST_IDLE: begin
                    fieldp <= '0;
                    if (start) begin
                        if (len_in_c == '0) begin
                            done <= 1'b1;
                        end else begin
                            seq_q  <= seq_in_c;
                            len_q  <= len_in_c;
                            loop_q <= seqctrl[3];
                            idx_q  <= '0;
                            bufp   <= entry_of(seq_in_c, '0);
                            fieldp <= FIRST_FIELD;
                            busy   <= 1'b1;
                            state  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        pat_valid <= pat_valid && !pat_ready;
                        state     <= ST_DRAIN;
                    end else if (xfer_c) begin
                        pat_data  <= patternbyte;
                        pat_valid <= 1'b1;
                        if (at_last_c) begin
                            fieldp <= FIRST_FIELD;
                            if (wraps_c) begin
                                idx_q <= next_idx_c;
                                bufp  <= next_buf_c;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            fieldp <= fieldp + FW'(1);
                        end
                    end else begin
                        pat_valid <= pat_valid && !pat_ready;
                    end
                end
                ST_DRAIN: begin
                    if (!pat_valid) begin
                        done   <= 1'b1;
                        fieldp <= '0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        pat_valid <= !pat_ready;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed/randomized bench for pattern_scheduler: a random bank image, a queue of
// expected bytes built from the sequence rules, and a randomized valid/ready consumer.
module tb_pattern_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] seq1 = '0;
    logic [7:0] seq2 = '0;
    logic [7:0] seqctrl = '0;
    logic [2:0] bufp;
    logic [4:0] fieldp;
    logic [7:0] patternbyte;
    logic [7:0] pat_data;
    logic       pat_valid;
    logic       pat_ready = 1'b1;
    logic       busy;
    logic       done;
    logic       wr_req = 1'b0;
    logic [2:0] wr_addr = '0;
    logic       wr_gnt;

    logic [7:0] mem [8][32];
    logic [7:0] expq[$];

    int vectors = 0;
    int miscompares = 0;
    int rx_cnt = 0;
    int done_cnt = 0;
    int exp_total = 0;
    int ready_mode = 0;
    bit consec = 1'b0;
    bit prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    pattern_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .seq1(seq1), .seq2(seq2), .seqctrl(seqctrl),
        .bufp(bufp), .fieldp(fieldp), .patternbyte(patternbyte),
        .pat_data(pat_data), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .busy(busy), .done(done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt)
    );

    always #5 clk = ~clk;

    always_comb patternbyte = mem[bufp][fieldp];

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream: every listed buffer's fields 3..26, entries in order.
    task automatic build_exp(input logic [15:0] s, input logic [7:0] ctrl, input int reps);
        int len;
        logic [2:0] b;
        len = int'(ctrl[2:0]);
        if (len > 5) len = 5;
        expq.delete();
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < len; k++) begin
                b = 3'(s >> (3 * k));
                for (int f = 3; f <= 26; f++) expq.push_back(mem[b][f]);
            end
        exp_total = expq.size();
        rx_cnt = 0;
        done_cnt = 0;
        prev_hold = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then drive ready for the next rising edge.
    task automatic cycle();
        @(negedge clk);
        if (prev_hold) begin
            check("hold_valid", 32'(pat_valid), 32'd1);
            check("hold_data", 32'(pat_data), 32'(prev_data));
        end
        if (consec && rx_cnt > 0 && rx_cnt < exp_total) check("consec_valid", 32'(pat_valid), 32'd1);
        if (done) done_cnt++;
        case (ready_mode)
            0: pat_ready = 1'b1;
            1: pat_ready = ~pat_ready;
            default: pat_ready = 1'($urandom_range(0, 1));
        endcase
        if (pat_valid && pat_ready) begin
            if (expq.size() == 0) check("extra_byte", 32'(expq.size()), 32'd1);
            else check("byte", 32'(pat_data), 32'(expq.pop_front()));
            rx_cnt++;
        end
        prev_hold = pat_valid && !pat_ready;
        prev_data = pat_data;
    endtask

    task automatic do_start(input logic [15:0] s, input logic [7:0] ctrl);
        seq1 = s[7:0];
        seq2 = s[15:8];
        seqctrl = ctrl;
        start = 1'b1;
        cycle();
        start = 1'b0;
        seq1 = 8'($urandom);
        seq2 = 8'($urandom);
        seqctrl = 8'($urandom);
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_count"}, 32'(rx_cnt), 32'(exp_total));
        cycle();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] s;
        logic [7:0]  ctrl;
        int n;

        for (int b = 0; b < 8; b++)
            for (int f = 0; f < 32; f++) mem[b][f] = 8'($urandom);

        #2 rst_n = 1'b0;
        #1;
        check("rst_pat_valid", 32'(pat_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({bufp, fieldp, pat_data, pat_valid, busy, done, wr_gnt}), 32'd0);
        rst_n = 1'b1;

        // Two entries, buf5 then buf2, consumer always ready.
        s = 16'h0015;
        build_exp(s, 8'h02, 1);
        ready_mode = 0;
        consec = 1'b1;
        do_start(s, 8'h02);
        check("t1_bufp", 32'(bufp), 32'd5);
        check("t1_fieldp", 32'(fieldp), 32'd3);
        check("t1_no_valid_yet", 32'(pat_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        cycle();
        check("t1_first_valid", 32'(pat_valid), 32'd1);
        check("t1_first_data", 32'(pat_data), 32'(mem[5][3]));
        run_to_done("t1", 200);
        consec = 1'b0;

        // Same sequence, consumer alternates ready.
        build_exp(s, 8'h02, 1);
        ready_mode = 1;
        do_start(s, 8'h02);
        run_to_done("t2", 300);

        // Clamped length 7 -> 5 entries, then random sequences under random backpressure.
        ready_mode = 2;
        s = 16'($urandom);
        build_exp(s, 8'h07, 1);
        do_start(s, 8'h07);
        run_to_done("t6_len7", 800);
        check("t6_len7_bytes", 32'(rx_cnt), 32'd120);
        for (int i = 0; i < 5; i++) begin
            s = 16'($urandom);
            ctrl = {4'($urandom), 1'b0, 3'($urandom_range(1, 7))};
            build_exp(s, ctrl, 1);
            do_start(s, ctrl);
            run_to_done("rand", 800);
        end

        // Single-entry loop on buf7, stopped after 30 bytes.
        ready_mode = 0;
        s = 16'h0007;
        build_exp(s, 8'h09, 3);
        do_start(s, 8'h09);
        n = 0;
        while (rx_cnt < 30 && n < 200) begin
            cycle();
            n++;
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        exp_total = 30;
        run_to_done("t3", 50);

        // Grant for a different buffer; playback stalls at buf5 f26 until released.
        s = 16'h0015;
        build_exp(s, 8'h02, 1);
        do_start(s, 8'h02);
        repeat (7) cycle();
        wr_addr = 3'd2;
        wr_req = 1'b1;
        cycle();
        check("t4_gnt_rise", 32'(wr_gnt), 32'd1);
        repeat (30) cycle();
        check("t4_stall_count", 32'(rx_cnt), 32'd23);
        check("t4_stall_ptr", 32'({bufp, fieldp}), 32'({3'd5, 5'd26}));
        check("t4_stall_valid", 32'(pat_valid), 32'd0);
        wr_req = 1'b0;
        cycle();
        check("t4_gnt_fall", 32'(wr_gnt), 32'd0);
        run_to_done("t4", 200);

        // Request for the playing buffer is withheld until playback moves on.
        build_exp(s, 8'h02, 1);
        do_start(s, 8'h02);
        cycle();
        wr_addr = 3'd5;
        wr_req = 1'b1;
        n = 0;
        while (bufp == 3'd5 && n < 100) begin
            cycle();
            check("t5_no_gnt", 32'(wr_gnt), 32'd0);
            n++;
        end
        check("t5_moved", 32'(bufp), 32'd2);
        cycle();
        check("t5_gnt", 32'(wr_gnt), 32'd1);
        wr_req = 1'b0;
        run_to_done("t5", 200);

        // Zero length: immediate done, nothing output.
        build_exp(16'h0015, 8'h00, 1);
        do_start(16'h0015, 8'h00);
        check("t6_len0_done", 32'(done), 32'd1);
        check("t6_len0_busy", 32'(busy), 32'd0);
        cycle();
        check("t6_len0_pulse", 32'(done), 32'd0);
        repeat (3) cycle();
        check("t6_len0_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_len0_no_bytes", 32'(rx_cnt), 32'd0);

        // Asynchronous reset in the middle of playback.
        ready_mode = 2;
        s = 16'($urandom);
        build_exp(s, 8'h05, 1);
        do_start(s, 8'h05);
        wr_addr = 3'(bufp + 3'd1);
        wr_req = 1'b1;
        repeat (20) cycle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", 32'({bufp, fieldp, pat_data, pat_valid, busy, done, wr_gnt}), 32'd0);
        @(negedge clk);
        wr_req = 1'b0;
        rst_n = 1'b1;
        prev_hold = 1'b0;
        done_cnt = 0;
        expq.delete();
        repeat (3) cycle();
        check("t6_rst_no_done", 32'(done_cnt), 32'd0);
        check("t6_rst_idle", 32'({busy, pat_valid}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
